// File: rtl/writeback_arb.sv
// Round-robin writeback arbiter: merges NUM_CH result channels onto one
// register-file write port with single-cycle latency and a saturating write counter.
module writeback_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*ADDR_W-1:0] ch_rd,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [CNT_W-1:0]         wr_count
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_idx;
    logic [NUM_CH-1:0] grant;
    logic              found;
    int                idx;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic [ADDR_W-1:0] rd_terms   [NUM_CH];
    logic [DATA_W-1:0] data_terms [NUM_CH];
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              fire;

    // Scan channels starting at rr_ptr, wrapping modulo NUM_CH; first valid wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!reset && !found && ch_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    assign ch_ready = grant;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
            assign rd_terms[gi]   = grant[gi] ? ch_rd[gi*ADDR_W +: ADDR_W]   : '0;
            assign data_terms[gi] = grant[gi] ? ch_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    // Grant is one-hot, so an OR across the masked terms is the selected channel.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_rd   = sel_rd | rd_terms[i];
            sel_data = sel_data | data_terms[i];
        end
    end

    always_comb begin
        fire       = |grant;
        wr_en_d    = fire && (sel_rd != '0);
        wr_addr_d  = wr_en_d ? sel_rd : wr_addr_q;
        wr_data_d  = wr_en_d ? sel_data : wr_data_q;
        wr_count_d = wr_count_q;
        if (wr_en_d && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_count = wr_count_q;

endmodule
